reg_file_sb: RTL and testbench

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/reg_file_pkg.sv | 21 ++
 rtl/reg_file_rd_port.sv | 45 ++++
 rtl/reg_file_sb.sv | 114 +++++++++++
 tb/tb_reg_file_sb.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Purpose: shared constants and types for the scoreboarded register file.
//   ADDR_W     - register address width
//   NREG       - number of architectural registers
//   REG_ZERO   - hard-wired zero register address
//   DATA_W_DEF - default register data width
package reg_file_pkg;

    localparam int unsigned ADDR_W     = 5;
    localparam int unsigned NREG       = 32;
    localparam int unsigned DATA_W_DEF = 32;

    typedef logic [ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

    // True for any address that names a writable register.
    function automatic logic is_wr_reg(input reg_addr_t addr);
        return addr != REG_ZERO;
    endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// Purpose: one register-file read port with write-through bypass and its
//          source-operand hazard term.
// Ports:
//   rs_addr, rs_used - source address and "operand actually read" flag
//   regs, busy       - stored registers and scoreboard busy vector
//   we, wa, wd       - write-back port (for bypass and hazard masking)
//   bypass_en        - forwarding allowed (low while in reset)
//   rs_data_c        - combinational read data
//   hz_c             - combinational hazard term for this operand
module reg_file_rd_port
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic [ADDR_W-1:0]            rs_addr,
    input  logic                         rs_used,
    input  logic [NREG-1:0][DATA_W-1:0]  regs,
    input  logic [NREG-1:0]              busy,
    input  logic                         we,
    input  logic [ADDR_W-1:0]            wa,
    input  logic [DATA_W-1:0]            wd,
    input  logic                         bypass_en,
    output logic [DATA_W-1:0]            rs_data_c,
    output logic                         hz_c
);

    logic wb_hit_c;

    // The write-back in flight this cycle targets this operand.
    assign wb_hit_c = we && (wa == rs_addr);

    // Address 0 beats bypass, bypass beats the stored value.
    always_comb begin
        rs_data_c = regs[rs_addr];
        if (!is_wr_reg(rs_addr)) begin
            rs_data_c = '0;
        end else if (bypass_en && wb_hit_c) begin
            rs_data_c = wd;
        end
    end

    // A busy source is fine if its writer lands this very cycle.
    assign hz_c = rs_used && busy[rs_addr] && !wb_hit_c;

endmodule

// File: rtl/reg_file_sb.sv
// Purpose: 32-entry register file with write-through read ports, a
//          destination scoreboard producing a stall, and a saturating
//          stall-cycle counter.
// Ports:
//   clk, rst_n                 - clock, synchronous active-low reset
//   rs1_addr/used, rs2_addr/used - source operands of the issuing instr
//   rs1_data, rs2_data         - combinational read data (bypassed)
//   we, wa, wd                 - write-back port
//   iss_valid, iss_rd          - issuing instruction's destination
//   stall                      - combinational source-operand hazard
//   dbg_addr, dbg_data         - debug read, stored value only
//   stall_cnt                  - saturating count of stall cycles
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic              rs1_used,
    input  logic [ADDR_W-1:0] rs2_addr,
    input  logic              rs2_used,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_rd,
    output logic              stall,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [NREG-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [NREG-1:0]             busy_q, busy_d;
    logic [CNT_W-1:0]            stall_cnt_q, stall_cnt_d;
    logic                        hz1_c, hz2_c;
    logic                        wr_en_c, set_en_c;

    assign wr_en_c  = we && is_wr_reg(wa);
    assign set_en_c = iss_valid && is_wr_reg(iss_rd);

    reg_file_rd_port #(.DATA_W(DATA_W)) u_rd_rs1 (
        .rs_addr   (rs1_addr),
        .rs_used   (rs1_used),
        .regs      (regs_q),
        .busy      (busy_q),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .bypass_en (rst_n),
        .rs_data_c (rs1_data),
        .hz_c      (hz1_c)
    );

    reg_file_rd_port #(.DATA_W(DATA_W)) u_rd_rs2 (
        .rs_addr   (rs2_addr),
        .rs_used   (rs2_used),
        .regs      (regs_q),
        .busy      (busy_q),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .bypass_en (rst_n),
        .rs_data_c (rs2_data),
        .hz_c      (hz2_c)
    );

    // Stall is suppressed during reset: the scoreboard is being wiped.
    assign stall = rst_n && (hz1_c || hz2_c);

    // Debug view shows committed state only.
    assign dbg_data = is_wr_reg(dbg_addr) ? regs_q[dbg_addr] : '0;

    assign stall_cnt = stall_cnt_q;

    // Next-state for storage, scoreboard and stall counter.
    always_comb begin
        regs_d      = regs_q;
        busy_d      = busy_q;
        stall_cnt_d = stall_cnt_q;

        if (wr_en_c) begin
            regs_d[wa] = wd;
            busy_d[wa] = 1'b0;
        end
        // Set after clear: a new writer overrides the retiring one.
        if (set_en_c) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[REG_ZERO] = 1'b0;

        if (stall && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs_q      <= '0;
            busy_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            regs_q      <= regs_d;
            busy_q      <= busy_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Purpose: self-checking bench for reg_file_sb: directed scenarios followed
//          by randomized traffic, all checked against a behavioural model
//          (plain arrays of register values, busy flags and a stall tally).
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs1_addr, rs2_addr, wa, iss_rd, dbg_addr;
    logic        rs1_used, rs2_used, we, iss_valid;
    logic [31:0] wd;
    logic [31:0] rs1_data, rs2_data, dbg_data;
    logic [31:0] rs1_data4, rs2_data4, dbg_data4;
    logic        stall, stall4;
    logic [15:0] stall_cnt;
    logic [3:0]  stall_cnt4;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state.
    logic [31:0] m_regs [32];
    bit          m_busy [32];
    int          m_stalls;

    always #5 clk = ~clk;

    reg_file_sb dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_addr(rs1_addr), .rs1_used(rs1_used),
        .rs2_addr(rs2_addr), .rs2_used(rs2_used),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .we(we), .wa(wa), .wd(wd),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .stall(stall),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .stall_cnt(stall_cnt)
    );

    // Narrow-counter instance shares all inputs; used for saturation.
    reg_file_sb #(.DATA_W(32), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .rs1_addr(rs1_addr), .rs1_used(rs1_used),
        .rs2_addr(rs2_addr), .rs2_used(rs2_used),
        .rs1_data(rs1_data4), .rs2_data(rs2_data4),
        .we(we), .wa(wa), .wd(wd),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .stall(stall4),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data4),
        .stall_cnt(stall_cnt4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (rst_n && we && wa == a) return wd;
        return m_regs[a];
    endfunction

    function automatic logic exp_stall();
        bit h1, h2;
        h1 = rs1_used && m_busy[rs1_addr] && !(we && wa == rs1_addr);
        h2 = rs2_used && m_busy[rs2_addr] && !(we && wa == rs2_addr);
        return rst_n && (h1 || h2);
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic check_all();
        chk("rs1_data",   64'(rs1_data),   64'(exp_read(rs1_addr)));
        chk("rs2_data",   64'(rs2_data),   64'(exp_read(rs2_addr)));
        chk("dbg_data",   64'(dbg_data),   64'((dbg_addr == 0) ? 32'h0 : m_regs[dbg_addr]));
        chk("stall",      64'(stall),      64'(exp_stall()));
        chk("stall_cnt",  64'(stall_cnt),  64'(sat(m_stalls, 65535)));
        chk("stall_cnt4", 64'(stall_cnt4), 64'(sat(m_stalls, 15)));
    endtask

    // Check the current cycle, then advance one edge and update the model.
    task automatic tick(input bit do_check);
        bit s;
        #1;
        if (do_check) check_all();
        s = exp_stall();
        @(posedge clk);
        if (!rst_n) begin
            foreach (m_regs[i]) begin m_regs[i] = '0; m_busy[i] = 0; end
            m_stalls = 0;
        end else begin
            if (s) m_stalls++;
            if (we && wa != 0) begin m_regs[wa] = wd; m_busy[wa] = 0; end
            if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1;
        end
        #1;
    endtask

    task automatic idle();
        rst_n = 1'b1; we = 1'b0; wa = '0; wd = '0;
        iss_valid = 1'b0; iss_rd = '0;
        rs1_addr = '0; rs2_addr = '0; rs1_used = 1'b0; rs2_used = 1'b0;
        dbg_addr = '0;
    endtask

    initial begin
        m_stalls = 0;
        foreach (m_regs[i]) begin m_regs[i] = '0; m_busy[i] = 0; end
        idle();

        // Initial reset; state is unknown before the first edge.
        rst_n = 1'b0;
        tick(0);
        tick(1);
        idle();
        rs1_addr = 5'd5; dbg_addr = 5'd31;
        tick(1);
        chk("reset_cnt", 64'(stall_cnt), 64'd0);

        // Write then read back.
        we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
        tick(1);
        idle(); rs1_addr = 5'd5; dbg_addr = 5'd5;
        #1;
        chk("wr_rs1", 64'(rs1_data), 64'h0DEADBEEF);
        chk("wr_dbg", 64'(dbg_data), 64'h0DEADBEEF);
        tick(1);

        // Same-cycle bypass on rs2, debug sees old value.
        we = 1'b1; wa = 5'd7; wd = 32'h12345678; rs2_addr = 5'd7; dbg_addr = 5'd7;
        #1;
        chk("byp_rs2", 64'(rs2_data), 64'h012345678);
        chk("byp_dbg", 64'(dbg_data), 64'h0);
        tick(1);

        // Register 0 is never written and never busy.
        idle(); we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; rs1_addr = 5'd0; rs1_used = 1'b1;
        iss_valid = 1'b1; iss_rd = 5'd0;
        tick(1);
        idle(); rs1_addr = 5'd0; rs1_used = 1'b1; rs2_addr = 5'd0; rs2_used = 1'b1;
        #1;
        chk("r0_rs1", 64'(rs1_data), 64'h0);
        chk("r0_stall", 64'(stall), 64'h0);
        tick(1);

        // Hazard: issue rd=3, stall three cycles, release by write-back.
        idle(); iss_valid = 1'b1; iss_rd = 5'd3;
        tick(1);
        idle(); rs1_addr = 5'd3; rs1_used = 1'b1;
        #1;
        chk("hz_stall", 64'(stall), 64'h1);
        for (int i = 0; i < 3; i++) tick(1);
        chk("hz_cnt3", 64'(stall_cnt), 64'd3);
        we = 1'b1; wa = 5'd3; wd = 32'hCAFE0003;
        #1;
        chk("hz_release", 64'(stall), 64'h0);
        chk("hz_fwd", 64'(rs1_data), 64'h0CAFE0003);
        tick(1);

        // Collision: set wins over clear on the same register.
        idle(); iss_valid = 1'b1; iss_rd = 5'd9; we = 1'b1; wa = 5'd9; wd = 32'h99;
        tick(1);
        idle(); rs2_addr = 5'd9; rs2_used = 1'b1;
        #1;
        chk("coll_stall", 64'(stall), 64'h1);
        tick(1);

        // Reset with busy bits set clears everything.
        idle(); iss_valid = 1'b1; iss_rd = 5'd4;
        tick(1);
        idle(); rst_n = 1'b0; rs1_addr = 5'd4; rs1_used = 1'b1; we = 1'b1; wa = 5'd4; wd = 32'h44;
        #1;
        chk("rst_stall", 64'(stall), 64'h0);
        chk("rst_nobyp", 64'(rs1_data), 64'h0);
        tick(1);
        idle(); rs1_addr = 5'd4; rs1_used = 1'b1;
        #1;
        chk("post_rst_stall", 64'(stall), 64'h0);
        for (int a = 0; a < 32; a++) begin
            dbg_addr = 5'(a);
            #1;
            chk("post_rst_reg", 64'(dbg_data), 64'h0);
        end
        tick(1);

        // Saturation: 20 stall cycles on both counter widths.
        idle(); iss_valid = 1'b1; iss_rd = 5'd2;
        tick(1);
        idle(); rs2_addr = 5'd2; rs2_used = 1'b1;
        for (int i = 0; i < 20; i++) tick(1);
        chk("sat_cnt4", 64'(stall_cnt4), 64'd15);
        chk("sat_cnt16", 64'(stall_cnt), 64'd20);

        // Randomized traffic on a narrow address window to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            rst_n     = ($urandom_range(0, 59) != 0);
            we        = 1'($urandom_range(0, 1));
            wa        = 5'($urandom_range(0, 7));
            wd        = $urandom;
            iss_valid = 1'($urandom_range(0, 1));
            iss_rd    = 5'($urandom_range(0, 7));
            rs1_addr  = 5'($urandom_range(0, 7));
            rs2_addr  = 5'($urandom_range(0, 7));
            rs1_used  = 1'($urandom_range(0, 1));
            rs2_used  = 1'($urandom_range(0, 1));
            dbg_addr  = 5'($urandom_range(0, 31));
            tick(1);
        end
        idle();
        tick(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
